queue_access_arbiter: RTL and testbench

//   Shares one FIFO-ordered 8-bit register-array queue between NUM_REQ requesters.

---
 rtl/queue_access_arbiter.sv | 135 +++++++++++++
 tb/tb_queue_access_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_access_arbiter.sv
// Round-robin arbitrated access to one shared FIFO register-array queue.
// One push or pop per cycle; pop data returns registered, one cycle after grant.
module queue_access_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int ID_W    = 2,
    parameter int PTR_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        op_wr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic [ID_W-1:0]           rd_id,
    output logic [PTR_W:0]            count,
    output logic                      full,
    output logic                      empty
);

    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q,  count_d;
    logic [ID_W-1:0]    last_q,   last_d;
    logic               rv_q,     rv_d;
    logic [DATA_W-1:0]  rdata_q,  rdata_d;
    logic [ID_W-1:0]    rid_q,    rid_d;

    logic [NUM_REQ-1:0] elig;
    logic               hit;
    logic [ID_W-1:0]    win;
    int                 idx;
    logic               commit;
    logic               push;
    logic               pop;
    logic [DATA_W-1:0]  wsel;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);

    // A request only competes if its operation can complete this cycle.
    assign elig = req
                & ~(op_wr & {NUM_REQ{full}})
                & ~(~op_wr & {NUM_REQ{empty}});

    always_comb begin
        hit = 1'b0;
        win = '0;
        idx = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!hit && elig[ID_W'(idx)]) begin
                hit = 1'b1;
                win = ID_W'(idx);
            end
        end
    end

    assign commit = hit & rst;
    assign push   = commit & op_wr[win];
    assign pop    = commit & ~op_wr[win];
    assign wsel   = wdata[int'(win)*DATA_W +: DATA_W];

    always_comb begin
        gnt = '0;
        if (commit) begin
            gnt[win] = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        rv_d     = 1'b0;
        rdata_d  = rdata_q;
        rid_d    = rid_q;
        if (commit) begin
            last_d = win;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
            rv_d     = 1'b1;
            rdata_d  = mem_q[rd_ptr_q];
            rid_d    = win;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= ID_W'(NUM_REQ - 1);
            rv_q     <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            rv_q     <= rv_d;
            rdata_q  <= rdata_d;
            rid_q    <= rid_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wsel;
        end
    end

    assign rd_valid = rv_q;
    assign rd_data  = rdata_q;
    assign rd_id    = rid_q;
    assign count    = count_q;

endmodule

// File: tb/tb_queue_access_arbiter.sv
// Randomized and directed checks of queue_access_arbiter against a queue model.
// Inputs change on the falling edge; outputs are sampled just after each edge.
module tb_queue_access_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  op_wr;
    logic [N*8-1:0] wdata;
    logic [N-1:0]  gnt;
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic [1:0]    rd_id;
    logic [4:0]    count;
    logic          full;
    logic          empty;

    queue_access_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .op_wr(op_wr), .wdata(wdata),
        .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] mq[$];
    int         m_last = N - 1;
    logic       m_rv   = 1'b0;
    logic [7:0] m_rd   = '0;
    logic [1:0] m_rid  = '0;

    function automatic logic [N-1:0] exp_gnt();
        if (rst !== 1'b1) return '0;
        for (int k = 1; k <= N; k++) begin
            int  i;
            bit  ok;
            i  = (m_last + k) % N;
            ok = req[i] && (op_wr[i] ? (mq.size() < 16) : (mq.size() > 0));
            if (ok) return N'(1) << i;
        end
        return '0;
    endfunction

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] o,
                         input logic [N*8-1:0] d, input logic rs);
        @(negedge clk);
        req = r; op_wr = o; wdata = d; rst = rs;
        #1;
    endtask

    task automatic tick();
        logic [N-1:0] g;
        g = exp_gnt();
        @(posedge clk);
        if (rst !== 1'b1) begin
            mq.delete();
            m_last = N - 1; m_rv = 0; m_rd = '0; m_rid = '0;
        end else begin
            m_rv = 0;
            for (int w = 0; w < N; w++) begin
                if (g[w]) begin
                    m_last = w;
                    if (op_wr[w]) mq.push_back(wdata[w*8 +: 8]);
                    else begin
                        m_rd = mq.pop_front(); m_rid = 2'(w); m_rv = 1;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive('0, '0, '0, 1'b0); tick();
        drive('0, '0, '0, 1'b0); tick();
        for (int c = 0; c < 3; c++) begin
            drive('0, '0, '0, 1'b1);
            n_total++;
            if (gnt !== '0) $display("FAIL reset_gnt got=%b exp=0", gnt);
            else n_pass++;
            tick();
            n_total++;
            if (empty !== 1'b1 || count !== 5'd0 || rd_valid !== 1'b0)
                $display("FAIL reset_state got e=%b c=%0d rv=%b exp e=1 c=0 rv=0",
                         empty, count, rd_valid);
            else n_pass++;
        end
    endtask

    task automatic test_fifo_order();
        for (int i = 0; i < 4; i++) begin
            drive(4'b0001, 4'b0001, {24'h0, 8'(8'hA1 + i)}, 1'b1);
            n_total++;
            if (gnt !== 4'b0001) $display("FAIL push_gnt got=%b exp=0001", gnt);
            else n_pass++;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(4'b0100, 4'b0000, '0, 1'b1);
            n_total++;
            if (gnt !== 4'b0100) $display("FAIL pop_gnt got=%b exp=0100", gnt);
            else n_pass++;
            tick();
            n_total++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(8'hA1 + i) || rd_id !== 2'd2)
                $display("FAIL pop_data got rv=%b d=%h id=%0d exp rv=1 d=%h id=2",
                         rd_valid, rd_data, rd_id, 8'(8'hA1 + i));
            else n_pass++;
        end
        drive('0, '0, '0, 1'b1);
        tick();
        n_total++;
        if (empty !== 1'b1 || rd_valid !== 1'b0)
            $display("FAIL drained got e=%b rv=%b exp e=1 rv=0", empty, rd_valid);
        else n_pass++;
    endtask

    task automatic test_fill();
        drive('0, '0, '0, 1'b0); tick();
        for (int i = 0; i < 20; i++) begin
            logic [N-1:0] e;
            e = (i < 16) ? (N'(1) << (i % 4)) : '0;
            drive(4'hF, 4'hF, $urandom, 1'b1);
            n_total++;
            if (gnt !== e || gnt !== exp_gnt())
                $display("FAIL fill_gnt[%0d] got=%b exp=%b", i, gnt, e);
            else n_pass++;
            tick();
            n_total++;
            if (count !== 5'((i < 16) ? i + 1 : 16) || full !== (i >= 15))
                $display("FAIL fill_count[%0d] got c=%0d f=%b", i, count, full);
            else n_pass++;
        end
    endtask

    task automatic test_full_contention();
        drive(4'b1010, 4'b0010, $urandom, 1'b1);
        n_total++;
        if (gnt !== 4'b1000) $display("FAIL full_pop_first got=%b exp=1000", gnt);
        else n_pass++;
        tick();
        n_total++;
        if (count !== 5'd15 || rd_valid !== 1'b1 || rd_id !== 2'd3 || rd_data !== m_rd)
            $display("FAIL full_pop_data got c=%0d rv=%b id=%0d d=%h exp c=15 rv=1 id=3 d=%h",
                     count, rd_valid, rd_id, rd_data, m_rd);
        else n_pass++;
        drive(4'b1010, 4'b0010, $urandom, 1'b1);
        n_total++;
        if (gnt !== 4'b0010) $display("FAIL full_push_next got=%b exp=0010", gnt);
        else n_pass++;
        tick();
        n_total++;
        if (count !== 5'd16 || full !== 1'b1)
            $display("FAIL full_refill got c=%0d f=%b exp c=16 f=1", count, full);
        else n_pass++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) begin
            drive(4'b1000, 4'b0000, '0, 1'b1);
            tick();
            n_total++;
            if (rd_valid !== 1'b1 || rd_data !== m_rd)
                $display("FAIL drain[%0d] got rv=%b d=%h exp rv=1 d=%h",
                         i, rd_valid, rd_data, m_rd);
            else n_pass++;
        end
        for (int i = 0; i < 20; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            drive(4'b0001, 4'b0001, {24'h0, d}, 1'b1);
            tick();
            drive(4'b0010, 4'b0000, '0, 1'b1);
            n_total++;
            if (gnt !== 4'b0010) $display("FAIL wrap_gnt[%0d] got=%b exp=0010", i, gnt);
            else n_pass++;
            tick();
            n_total++;
            if (rd_valid !== 1'b1 || rd_data !== d || rd_id !== 2'd1)
                $display("FAIL wrap_data[%0d] got rv=%b d=%h id=%0d exp rv=1 d=%h id=1",
                         i, rd_valid, rd_data, rd_id, d);
            else n_pass++;
        end
        n_total++;
        if (count !== 5'd0 || empty !== 1'b1)
            $display("FAIL wrap_end got c=%0d e=%b exp c=0 e=1", count, empty);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] e;
            drive(N'($urandom), N'($urandom), $urandom, 1'b1);
            e = exp_gnt();
            n_total++;
            if (gnt !== e) $display("FAIL rand_gnt[%0d] got=%b exp=%b", i, gnt, e);
            else n_pass++;
            tick();
            n_total++;
            if (rd_valid !== m_rv || rd_data !== m_rd || rd_id !== m_rid ||
                count !== 5'(mq.size()) || full !== (mq.size() == 16) ||
                empty !== (mq.size() == 0))
                $display("FAIL rand_state[%0d] got rv=%b d=%h id=%0d c=%0d exp rv=%b d=%h id=%0d c=%0d",
                         i, rd_valid, rd_data, rd_id, count, m_rv, m_rd, m_rid, mq.size());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        drive('0, '0, '0, 1'b0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(4'b0001, 4'b0001, $urandom, 1'b1);
            tick();
        end
        drive(4'b0100, 4'b0000, '0, 1'b0);
        n_total++;
        if (gnt !== '0) $display("FAIL midrst_gnt got=%b exp=0", gnt);
        else n_pass++;
        tick();
        n_total++;
        if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0)
            $display("FAIL midrst_state got c=%0d e=%b rv=%b exp c=0 e=1 rv=0",
                     count, empty, rd_valid);
        else n_pass++;
        drive(4'b1010, 4'b1010, $urandom, 1'b1);
        n_total++;
        if (gnt !== 4'b0010) $display("FAIL midrst_first got=%b exp=0010", gnt);
        else n_pass++;
        tick();
        n_total++;
        if (count !== 5'd1 || rd_valid !== 1'b0)
            $display("FAIL midrst_push got c=%0d rv=%b exp c=1 rv=0", count, rd_valid);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b0; req = '0; op_wr = '0; wdata = '0;
        test_reset();
        test_fifo_order();
        test_fill();
        test_full_contention();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
